// File: rtl/io_bus_pkg.sv
// Shared definitions for the two-master I/O bus arbiter: default widths,
// bus encoding constants and the transaction state machine states.
package io_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 4;

    localparam int          WR_BIT     = 0;
    localparam logic [19:0] DEV_PREFIX = 20'hFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Counter must hold the larger wait count and never collapse to zero bits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 2);
    endfunction

endpackage

// File: rtl/io_bus_rr_pick.sv
// Two-input round-robin selector: a lone request wins outright, a tie goes
// to the master that was not granted last.
module io_bus_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            sel = ~last;
        end else begin
            sel = req[1];
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for a single shared I/O bus: captures one master's request,
// runs an address phase plus a region-dependent number of wait cycles, returns read data.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int ADDR_W   = io_bus_pkg::DEF_ADDR_W,
    parameter int DATA_W   = io_bus_pkg::DEF_DATA_W,
    parameter int CTRL_W   = io_bus_pkg::DEF_CTRL_W,
    parameter int RAM_WAIT = 1,
    parameter int DEV_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CTRL_W-1:0] m1_ctrl,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_bc,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [CTRL_W-1:0] bus_ctrl,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    localparam int CNT_W = cnt_width(RAM_WAIT, DEV_WAIT);
    localparam logic [CNT_W-1:0] RAM_WAIT_C = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] DEV_WAIT_C = CNT_W'(DEV_WAIT);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sel;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata [2];

    logic [1:0]        w_req;
    logic              w_sel;
    logic              w_valid;
    logic [CNT_W-1:0]  w_wait_load;
    logic [1:0]        w_gnt;
    logic [1:0]        w_done;
    logic              w_active;
    logic [ADDR_W-1:0] w_addr_in  [2];
    logic [CTRL_W-1:0] w_ctrl_in  [2];
    logic [DATA_W-1:0] w_wdata_in [2];

    assign w_req         = {m1_req, m0_req};
    assign w_addr_in[0]  = m0_addr;
    assign w_addr_in[1]  = m1_addr;
    assign w_ctrl_in[0]  = m0_ctrl;
    assign w_ctrl_in[1]  = m1_ctrl;
    assign w_wdata_in[0] = m0_wdata;
    assign w_wdata_in[1] = m1_wdata;

    io_bus_rr_pick u_pick (
        .req   (w_req),
        .last  (r_last),
        .sel   (w_sel),
        .valid (w_valid)
    );

    // The top 4 KiB page of the 32-bit map is the slow peripheral window.
    assign w_wait_load = (r_addr[31:12] == DEV_PREFIX) ? DEV_WAIT_C : RAM_WAIT_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_valid) w_state_next = ST_ADDR;
            ST_ADDR: w_state_next = (w_wait_load != '0) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (r_cnt <= CNT_W'(1)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_ctrl  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_sel   <= w_sel;
                        r_addr  <= w_addr_in[w_sel];
                        r_ctrl  <= w_ctrl_in[w_sel];
                        r_wdata <= w_wdata_in[w_sel];
                    end
                end
                ST_ADDR: r_cnt  <= w_wait_load;
                ST_WAIT: r_cnt  <= r_cnt - CNT_W'(1);
                ST_DONE: r_last <= r_sel;
                default: ;
            endcase
        end
    end

    // Read data lands on the edge that closes the DONE cycle and then holds.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign w_gnt[gi]  = (r_state == ST_ADDR) && (r_sel == 1'(gi));
        assign w_done[gi] = (r_state == ST_DONE) && (r_sel == 1'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata[gi] <= '0;
            end else if (w_done[gi]) begin
                r_rdata[gi] <= bus_rdata;
            end
        end
    end

    assign w_active = (r_state != ST_IDLE);

    always_comb begin
        busy        = w_active;
        bus_bc      = w_active;
        bus_addr    = w_active ? r_addr  : '0;
        bus_ctrl    = w_active ? r_ctrl  : '0;
        bus_wdata   = w_active ? r_wdata : '0;
        bus_data_oe = ((r_state == ST_ADDR) || (r_state == ST_WAIT)) && r_ctrl[WR_BIT];
    end

    assign m0_gnt   = w_gnt[0];
    assign m1_gnt   = w_gnt[1];
    assign m0_done  = w_done[0];
    assign m1_done  = w_done[1];
    assign m0_rdata = r_rdata[0];
    assign m1_rdata = r_rdata[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter: default instance plus a
// RAM_WAIT=0 instance sharing the same stimulus.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata;
    logic [3:0]  m0_ctrl, m1_ctrl;

    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_ctrl;
    logic        bus_bc, bus_data_oe, busy;

    logic        z_m0_gnt, z_m0_done, z_m1_gnt, z_m1_done;
    logic [31:0] z_m0_rdata, z_m1_rdata, z_bus_addr, z_bus_wdata;
    logic [3:0]  z_bus_ctrl;
    logic        z_bus_bc, z_bus_data_oe, z_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    io_bus_arbiter u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ctrl(m0_ctrl), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_ctrl(m1_ctrl), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .bus_bc(bus_bc), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl), .bus_wdata(bus_wdata),
        .bus_data_oe(bus_data_oe), .bus_rdata(bus_rdata), .busy(busy)
    );

    io_bus_arbiter #(.RAM_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ctrl(m0_ctrl), .m0_wdata(m0_wdata),
        .m0_gnt(z_m0_gnt), .m0_done(z_m0_done), .m0_rdata(z_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_ctrl(m1_ctrl), .m1_wdata(m1_wdata),
        .m1_gnt(z_m1_gnt), .m1_done(z_m1_done), .m1_rdata(z_m1_rdata),
        .bus_bc(z_bus_bc), .bus_addr(z_bus_addr), .bus_ctrl(z_bus_ctrl), .bus_wdata(z_bus_wdata),
        .bus_data_oe(z_bus_data_oe), .bus_rdata(bus_rdata), .busy(z_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m1_addr = 0; m0_ctrl = 0; m1_ctrl = 0;
        m0_wdata = 0; m1_wdata = 0; bus_rdata = 0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_bc", bus_bc, 0);
        chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
        chk("rst_done", {m0_done, m1_done}, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_addr", bus_addr, 0);
        rst = 1'b0;
        step();

        // m0 RAM read
        m0_req = 1; m0_addr = 32'h0000_1000; m0_ctrl = 4'h0; m0_wdata = 32'h1234;
        bus_rdata = 32'hDEAD_BEEF;
        step();
        m0_req = 0; m0_addr = 32'h0;
        chk("t1_gnt0", m0_gnt, 1);
        chk("t1_gnt1", m1_gnt, 0);
        chk("t1_bc", bus_bc, 1);
        chk("t1_addr", bus_addr, 32'h0000_1000);
        chk("t1_oe_a", bus_data_oe, 0);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_wait_gnt", m0_gnt, 0);
        chk("t1_wait_done", m0_done, 0);
        chk("t1_oe_w", bus_data_oe, 0);
        step();
        chk("t1_done", m0_done, 1);
        chk("t1_oe_d", bus_data_oe, 0);
        step();
        chk("t1_done_off", m0_done, 0);
        chk("t1_idle_bc", bus_bc, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_rdata0", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_rdata1", m1_rdata, 0);

        // m1 device write: 4 cycles of data drive, done 4 cycles after gnt
        m1_req = 1; m1_addr = 32'hFFFF_F060; m1_ctrl = 4'h1; m1_wdata = 32'h55;
        bus_rdata = 32'hCAFE_F00D;
        step();
        m1_req = 0;
        chk("t2_gnt1", m1_gnt, 1);
        chk("t2_oe0", bus_data_oe, 1);
        chk("t2_wdata", bus_wdata, 32'h55);
        chk("t2_ctrl", bus_ctrl, 4'h1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t2_oe_w", bus_data_oe, 1);
            chk("t2_nodone", m1_done, 0);
        end
        step();
        chk("t2_done", m1_done, 1);
        chk("t2_oe_d", bus_data_oe, 0);
        step();
        chk("t2_idle_bc", bus_bc, 0);
        chk("t2_rdata0_held", m0_rdata, 32'hDEAD_BEEF);

        // both requesting: m0, m1, m0, m1 with an idle gap between each
        m0_req = 1; m0_addr = 32'h2000; m0_ctrl = 0;
        m1_req = 1; m1_addr = 32'h3000; m1_ctrl = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_gnt0", m0_gnt, (k % 2 == 0) ? 1 : 0);
            chk("t3_gnt1", m1_gnt, (k % 2 == 1) ? 1 : 0);
            chk("t3_addr", bus_addr, (k % 2 == 0) ? 32'h2000 : 32'h3000);
            step(); step();
            chk("t3_done", {m1_done, m0_done}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 3) begin
                m0_req = 0; m1_req = 0;
            end
            step();
            chk("t3_gap_bc", bus_bc, 0);
        end
        step();
        chk("t3_quiet", busy, 0);

        // m0 completes so last-granted is m0, then m1 device read is aborted by reset
        m0_req = 1; m0_addr = 32'h4000;
        step();
        m0_req = 0;
        step(); step();
        chk("t4_pre_done", m0_done, 1);
        step();
        m1_req = 1; m1_addr = 32'hFFFF_F000; m1_ctrl = 0;
        step();
        m1_req = 0;
        chk("t4_gnt1", m1_gnt, 1);
        step(); step();
        chk("t4_in_wait", busy, 1);
        rst = 1;
        step();
        rst = 0;
        chk("t4_abort_bc", bus_bc, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", m1_done, 0);
        step();
        chk("t4_still_idle", {busy, m1_done}, 0);
        m0_req = 1; m1_req = 1; m0_addr = 32'h6000; m1_addr = 32'h7000;
        step();
        m0_req = 0; m1_req = 0;
        chk("t4_tie_gnt0", m0_gnt, 1);
        chk("t4_tie_gnt1", m1_gnt, 0);
        step(); step(); step();

        // zero RAM wait: done one cycle after gnt
        rst = 1;
        step();
        rst = 0;
        m0_req = 1; m0_addr = 32'h5000; m0_ctrl = 0; bus_rdata = 32'h0BAD_F00D;
        step();
        m0_req = 0;
        chk("t5_gnt", z_m0_gnt, 1);
        chk("t5_gnt_nodone", z_m0_done, 0);
        step();
        chk("t5_done", z_m0_done, 1);
        chk("t5_done_bc", z_bus_bc, 1);
        step();
        chk("t5_after_done", z_m0_done, 0);
        chk("t5_after_bc", z_bus_bc, 0);
        chk("t5_rdata", z_m0_rdata, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width.
REQ-003 SHALL have parameter CTRL_W, default 4, bus control width.
REQ-004 SHALL have parameter RAM_WAIT, default 1, wait cycles for main-memory accesses.
REQ-005 SHALL have parameter DEV_WAIT, default 3, wait cycles for peripheral accesses.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL provide per master x in {0,1}: mx_req  in  1  request; mx_addr  in  ADDR_W  address; mx_ctrl  in  CTRL_W  control; mx_wdata  in  DATA_W  write data.
REQ-008 SHALL provide per master x: mx_gnt  out  1  one-cycle grant pulse; mx_done  out  1  one-cycle completion pulse; mx_rdata  out  DATA_W  read data.
REQ-009 SHALL provide bus side: bus_bc  out  1  bus query/cycle active; bus_addr  out  ADDR_W; bus_ctrl  out  CTRL_W; bus_wdata  out  DATA_W; bus_data_oe  out  1  write-data drive enable; bus_rdata  in  DATA_W.
REQ-010 SHALL provide busy  out  1, high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, ADDR, WAIT, DONE.
REQ-012 In IDLE with exactly one req high, SHALL select that master; with both high, SHALL select the master not granted last (round-robin); with none, SHALL stay in IDLE.
REQ-013 On selection, SHALL capture that master's addr/ctrl/wdata into internal registers, go to ADDR, and assert its mx_gnt during the ADDR cycle only.
REQ-014 In ADDR, SHALL load the wait counter with DEV_WAIT if captured addr[31:12] == 20'hFFFFF, else RAM_WAIT; go to WAIT if the loaded value is nonzero, else DONE.
REQ-015 In WAIT, SHALL decrement the counter each cycle and enter DONE on the cycle after it reaches 1.
REQ-016 bus_bc, bus_addr, bus_ctrl and bus_wdata SHALL be driven from the captured registers in ADDR, WAIT and DONE, and be low/zero in IDLE.
REQ-017 bus_data_oe SHALL equal captured ctrl[0] (write bit) in ADDR and WAIT, and be low otherwise.
REQ-018 In DONE, SHALL register bus_rdata into the granted master's mx_rdata, pulse its mx_done, record it as last-granted, and return to IDLE.
REQ-019 mx_done SHALL occur exactly N+1 cycles after mx_gnt, N being the selected wait count.
REQ-020 mx_rdata SHALL hold its value until that master's next mx_done, including after write transactions.
REQ-021 A req dropped before being selected SHALL cause no bus activity; req changes after gnt SHALL NOT affect the transaction in flight.
REQ-022 Between consecutive transactions, bus_bc SHALL be low for at least one cycle (the IDLE cycle).
REQ-023 A master holding req continuously while the other also requests SHALL alternate grants, with no starvation.

Reset
REQ-024 With rst high at a clock edge, SHALL enter IDLE; all outputs SHALL be 0 and last-granted SHALL be master 1, so master 0 wins the first tie.
REQ-025 Reset asserted mid-transaction SHALL abort it with no mx_done, and bus_bc SHALL be low on the following cycle.

Structure
REQ-026 Package io_bus_pkg SHALL hold ADDR_W/DATA_W/CTRL_W defaults, WR_BIT=0, DEV_PREFIX=20'hFFFFF, and the state enum.
REQ-027 The two-input round-robin pick SHALL be a sub-module io_bus_rr_pick (inputs req[1:0], last; output sel, valid).

Verification
REQ-028 m0 read of 0x0000_1000, bus_rdata=0xDEADBEEF -> m0_gnt, then m0_done 2 cycles later with m0_rdata=0xDEADBEEF; bus_data_oe stays 0.
REQ-029 m1 write of 0xFFFF_F060, ctrl[0]=1, wdata=0x55 -> bus_data_oe=1 for 4 cycles, and m1_done 4 cycles after m1_gnt.
REQ-030 m0_req and m1_req both held high for 4 transactions -> grant order m0, m1, m0, m1, with bus_bc low for one cycle between each.
REQ-031 rst pulsed during WAIT of a device access -> no done, bus_bc=0 and busy=0 next cycle, and the next tie is granted to m0.
REQ-032 RAM_WAIT=0 override, m0 read -> m0_done 1 cycle after m0_gnt, with no WAIT state visited.
